// File: rtl/video_timing_gen.sv
// Free-running raster timing generator. It produces counters, syncs, DE and frame/tick strobes,
// plus copies of HS/VS/DE that are delayed to match the renderer latency.
module video_timing_gen #(
  parameter int unsigned H_ACTIVE    = 1024,
  parameter int unsigned H_FP        = 24,
  parameter int unsigned H_SYNC      = 136,
  parameter int unsigned H_BP        = 160,
  parameter int unsigned V_ACTIVE    = 768,
  parameter int unsigned V_FP        = 3,
  parameter int unsigned V_SYNC      = 6,
  parameter int unsigned V_BP        = 29,
  parameter bit          HS_POL      = 1'b0,
  parameter bit          VS_POL      = 1'b0,
  parameter int unsigned SYNC_DELAY  = 2,
  parameter int unsigned TICK_FRAMES = 60
) (
  input  logic        i_clk_74M,
  input  logic        i_rst_n,
  input  logic        i_en,
  output logic [11:0] o_hcnt,
  output logic [11:0] o_vcnt,
  output logic        o_hs,
  output logic        o_vs,
  output logic        o_de,
  output logic        o_hs_d,
  output logic        o_vs_d,
  output logic        o_de_d,
  output logic        o_line_start,
  output logic        o_frame_start,
  output logic        o_tick
);

  localparam logic [11:0] H_LAST   = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [11:0] V_LAST   = 12'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [11:0] H_ACT    = 12'(H_ACTIVE);
  localparam logic [11:0] V_ACT    = 12'(V_ACTIVE);
  localparam logic [11:0] HS_START = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] VS_START = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_END   = 12'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [7:0]  TICK_LAST = 8'(TICK_FRAMES - 1);

  logic [11:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic        hs_q, hs_d, vs_q, vs_d, de_q, de_d;
  logic        line_q, line_d, frame_q, frame_d, tick_q, tick_d;
  logic [7:0]  fcnt_q, fcnt_d;

  // Flags are derived from the next counter values so that they line up with the registered counters.
  always_comb begin
    hcnt_d  = hcnt_q;
    vcnt_d  = vcnt_q;
    hs_d    = hs_q;
    vs_d    = vs_q;
    de_d    = de_q;
    fcnt_d  = fcnt_q;
    line_d  = 1'b0;
    frame_d = 1'b0;
    tick_d  = 1'b0;
    if (i_en) begin
      if (hcnt_q == H_LAST) begin
        hcnt_d = '0;
        vcnt_d = (vcnt_q == V_LAST) ? 12'd0 : vcnt_q + 12'd1;
      end else begin
        hcnt_d = hcnt_q + 12'd1;
      end
      de_d    = (hcnt_d < H_ACT) && (vcnt_d < V_ACT);
      hs_d    = ((hcnt_d >= HS_START) && (hcnt_d < HS_END)) ? HS_POL : ~HS_POL;
      vs_d    = ((vcnt_d >= VS_START) && (vcnt_d < VS_END)) ? VS_POL : ~VS_POL;
      line_d  = (hcnt_d == 12'd0);
      frame_d = line_d && (vcnt_d == 12'd0);
      if (frame_d) begin
        if (fcnt_q == TICK_LAST) begin
          fcnt_d = '0;
          tick_d = 1'b1;
        end else begin
          fcnt_d = fcnt_q + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge i_clk_74M or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hcnt_q  <= H_LAST;
      vcnt_q  <= V_LAST;
      hs_q    <= ~HS_POL;
      vs_q    <= ~VS_POL;
      de_q    <= 1'b0;
      line_q  <= 1'b0;
      frame_q <= 1'b0;
      tick_q  <= 1'b0;
      fcnt_q  <= '0;
    end else begin
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      de_q    <= de_d;
      line_q  <= line_d;
      frame_q <= frame_d;
      tick_q  <= tick_d;
      fcnt_q  <= fcnt_d;
    end
  end

  assign o_hcnt        = hcnt_q;
  assign o_vcnt        = vcnt_q;
  assign o_hs          = hs_q;
  assign o_vs          = vs_q;
  assign o_de          = de_q;
  assign o_line_start  = line_q;
  assign o_frame_start = frame_q;
  assign o_tick        = tick_q;

  // The delay line keeps shifting while the raster is frozen, so the pins drain to the held state.
  generate
    if (SYNC_DELAY == 0) begin : g_no_dly
      assign o_hs_d = hs_q;
      assign o_vs_d = vs_q;
      assign o_de_d = de_q;
    end else begin : g_dly
      logic [SYNC_DELAY-1:0][2:0] dly_q;
      always_ff @(posedge i_clk_74M or negedge i_rst_n) begin
        if (!i_rst_n) begin
          for (int i = 0; i < SYNC_DELAY; i++) dly_q[i] <= {~HS_POL, ~VS_POL, 1'b0};
        end else begin
          dly_q[0] <= {hs_q, vs_q, de_q};
          for (int i = 1; i < SYNC_DELAY; i++) dly_q[i] <= dly_q[i-1];
        end
      end
      assign o_hs_d = dly_q[SYNC_DELAY-1][2];
      assign o_vs_d = dly_q[SYNC_DELAY-1][1];
      assign o_de_d = dly_q[SYNC_DELAY-1][0];
    end
  endgenerate

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen on a reduced raster geometry, so that several frames fit in a short run.
// A linear-position reference model predicts every output on every cycle.
module tb_video_timing_gen;

  localparam int HA = 20, HFP = 3, HSW = 4, HBP = 5;
  localparam int VA = 12, VFP = 2, VSW = 3, VBP = 3;
  localparam int HT = HA + HFP + HSW + HBP;
  localparam int VT = VA + VFP + VSW + VBP;
  localparam int PTOT = HT * VT;
  localparam int DLY = 2;
  localparam int TF = 3;

  logic        clk = 1'b0;
  logic        rst_n, en;
  logic [11:0] hcnt, vcnt;
  logic        hs, vs, de, hs_d, vs_d, de_d, line_s, frame_s, tick;

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .HS_POL(1'b0), .VS_POL(1'b0), .SYNC_DELAY(DLY), .TICK_FRAMES(TF)
  ) dut (
    .i_clk_74M(clk), .i_rst_n(rst_n), .i_en(en),
    .o_hcnt(hcnt), .o_vcnt(vcnt), .o_hs(hs), .o_vs(vs), .o_de(de),
    .o_hs_d(hs_d), .o_vs_d(vs_d), .o_de_d(de_d),
    .o_line_start(line_s), .o_frame_start(frame_s), .o_tick(tick)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Model state: linear pixel index within the frame, edges since reset, frame starts seen.
  int pos, k_edges, frames, ticks_seen;
  bit m_line, m_frame, m_tick;
  logic [2:0] exp_q[$];

  function automatic logic [2:0] flags_of(input int p);
    int h, v;
    logic fh, fv, fd;
    h  = p % HT;
    v  = p / HT;
    fd = (h < HA) && (v < VA);
    fh = !((h >= HA + HFP) && (h < HA + HFP + HSW));
    fv = !((v >= VA + VFP) && (v < VA + VFP + VSW));
    return {fh, fv, fd};
  endfunction

  task automatic model_reset();
    pos = PTOT - 1;
    k_edges = 0;
    frames = 0;
    m_line = 0; m_frame = 0; m_tick = 0;
    exp_q.delete();
    exp_q.push_back(flags_of(pos));
  endtask

  task automatic model_step(input bit en_v);
    k_edges++;
    m_line = 0; m_frame = 0; m_tick = 0;
    if (en_v) begin
      pos = (pos + 1) % PTOT;
      m_line  = (pos % HT) == 0;
      m_frame = (pos == 0);
      if (m_frame) begin
        frames++;
        m_tick = (frames % TF) == 0;
      end
    end
    exp_q.push_back(flags_of(pos));
  endtask

  task automatic check_all();
    logic [2:0] f, fd;
    f  = flags_of(pos);
    fd = (k_edges >= DLY) ? exp_q[k_edges - DLY] : exp_q[0];
    chk("hcnt", 32'(hcnt), 32'(pos % HT));
    chk("vcnt", 32'(vcnt), 32'(pos / HT));
    chk("hs", 32'(hs), 32'(f[2]));
    chk("vs", 32'(vs), 32'(f[1]));
    chk("de", 32'(de), 32'(f[0]));
    chk("hs_d", 32'(hs_d), 32'(fd[2]));
    chk("vs_d", 32'(vs_d), 32'(fd[1]));
    chk("de_d", 32'(de_d), 32'(fd[0]));
    chk("line_start", 32'(line_s), 32'(m_line));
    chk("frame_start", 32'(frame_s), 32'(m_frame));
    chk("tick", 32'(tick), 32'(m_tick));
    if (tick === 1'b1) ticks_seen++;
  endtask

  task automatic run_cycle(input bit en_v);
    en = en_v;
    @(posedge clk);
    model_step(en_v);
    @(negedge clk);
    check_all();
  endtask

  task automatic reset_hold(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      @(negedge clk);
      check_all();
      chk("rst_hcnt", 32'(hcnt), 32'(HT - 1));
      chk("rst_vcnt", 32'(vcnt), 32'(VT - 1));
      chk("rst_hs_vs", 32'({hs, vs, de}), 32'(3'b110));
    end
  endtask

  initial begin
    int budget;
    rst_n = 1'b0;
    en    = 1'b1;
    ticks_seen = 0;
    model_reset();
    reset_hold(5);

    rst_n = 1'b1;
    run_cycle(1'b1);
    chk("first_hcnt", 32'(hcnt), 0);
    chk("first_vcnt", 32'(vcnt), 0);
    chk("first_de", 32'(de), 1);
    chk("first_frame_start", 32'(frame_s), 1);
    chk("first_tick", 32'(tick), 0);

    // Freeze at the last active pixel of line 0.
    while (pos != HA - 1) run_cycle(1'b1);
    for (int i = 0; i < 10; i++) begin
      run_cycle(1'b0);
      chk("hold_hcnt", 32'(hcnt), 32'(HA - 1));
    end
    run_cycle(1'b1);
    chk("resume_hcnt", 32'(hcnt), 32'(HA));
    chk("resume_de", 32'(de), 0);

    // Randomised enable until seven frame starts have been seen.
    budget = 20 * PTOT;
    while (frames < 7 && budget > 0) begin
      run_cycle($urandom_range(0, 9) != 0);
      budget--;
    end
    chk("frames_budget", 32'(budget > 0), 1);
    chk("tick_count", 32'(ticks_seen), 2);

    // Reset abandoned mid-frame, asserted between clock edges.
    budget = 4 * PTOT;
    while (pos / HT != VT / 2 && budget > 0) begin
      run_cycle($urandom_range(0, 3) != 0);
      budget--;
    end
    chk("midframe_budget", 32'(budget > 0), 1);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    chk("async_hcnt", 32'(hcnt), 32'(HT - 1));
    @(negedge clk);
    reset_hold(3);
    rst_n = 1'b1;
    run_cycle(1'b1);
    chk("restart_hcnt", 32'(hcnt), 0);
    chk("restart_frame_start", 32'(frame_s), 1);
    for (int i = 0; i < 2 * HT + $urandom_range(0, HT); i++) run_cycle($urandom_range(0, 7) != 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
